st7735_spi_receiver: RTL
========================

Name: st7735_spi_receiver

Overview:
- 4-wire write-only SPI slave: inputs CS, LCD_CLK, MOSI, DC, MSB-first, sampled on rising LCD_CLK; outputs a stream of decoded command/parameter bytes.
- Serves as the panel-side counterpart of the ST7735 init driver.
- Used as an on-chip loopback checker and bus sniffer, in the SYSTEM_CLK domain.
- Oversamples the bus: LCD_CLK frequency must not exceed SYSTEM_CLK/4.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronizers (minimum 2)
PARAM_IDX_W, 5, width of the parameter index; the index saturates at 2^PARAM_IDX_W-1
CMD_CNT_W, 16, width of the command counter; the counter wraps

Ports:
SYSTEM_CLK  in  1  system clock, all logic on its rising edge
SYSTEM_RST  in  1  asynchronous, active-high reset
LCD_CS  in  1  chip select, active low, asynchronous to SYSTEM_CLK
LCD_CLK  in  1  serial clock, idles high, asynchronous
LCD_MOSI  in  1  serial data
LCD_DC  in  1  0 = command byte, 1 = parameter byte
byte_valid  out  1  one-cycle pulse per completed byte
byte_data  out  8  received byte, held until the next byte
byte_is_data  out  1  DC value captured with byte_data
cmd_code  out  8  most recent command byte
param_idx  out  PARAM_IDX_W  index of the current parameter; first parameter after a command = 0
cmd_count  out  CMD_CNT_W  number of command bytes received since reset
frame_error  out  1  one-cycle pulse: CS rose with 1-7 bits shifted
orphan_data  out  1  one-cycle pulse: parameter byte received with no command since reset
busy  out  1  high while CS is low (synchronized)

Behaviour:
- Reset: every output is 0. Shift register and bit counter are cleared. The internal have_cmd flag is cleared. Reset is taken immediately, including in the middle of a byte.
- Synchronizers: LCD_CS, LCD_CLK, LCD_MOSI and LCD_DC each pass through SYNC_STAGES flops. Synchronized CS and CLK reset to 1; MOSI and DC reset to 0.
- Edge detection: sclk_rise = synchronized CLK is 1 and its previous value was 0. MOSI and DC are taken from the same synchronized sample, so they stay aligned with CLK.
- FSM state IDLE:
  - busy = 0; bit_cnt is held at 0.
  - Synchronized CS falling moves to SHIFT on the next cycle.
- FSM state SHIFT:
  - On each sclk_rise: sh <= {sh[6:0], MOSI}; bit_cnt <= bit_cnt+1.
  - DC is latched only on the 8th rise. DC changes during bits 1-7 are ignored.
  - On the 8th rise, on the following cycle:
    - byte_valid = 1; byte_data = the full byte; byte_is_data = latched DC; bit_cnt = 0.
    - The FSM stays in SHIFT, so consecutive bytes need no CS toggle.
  - sclk_rise is ignored while CS is high.
- Leaving SHIFT: synchronized CS rising returns to IDLE.
  - If bit_cnt != 0, pulse frame_error and discard the partial byte: no byte_valid, no other output changes.
  - If the 8th rise and the CS rise land in the same cycle, the byte completes normally (byte_valid) and no frame_error is raised.
- Command decode, on the byte_valid cycle:
  - DC = 0: cmd_code = byte; param_idx = 0; cmd_count = cmd_count+1 (wraps); have_cmd = 1.
  - DC = 1 with have_cmd = 1: param_idx is the index of this byte. It increments after each parameter and saturates at all-ones.
  - DC = 1 with have_cmd = 0: byte_valid still pulses and orphan_data pulses in the same cycle; param_idx stays 0.
  - The first parameter after a command reports param_idx = 0. A new command resets the index to 0.
- Command context across CS: CS deassertion does not clear have_cmd or cmd_code. Parameters may follow the command in a later CS frame.
- Latency: byte_valid occurs SYNC_STAGES+2 SYSTEM_CLK cycles after the 8th LCD_CLK rising edge at the pins (±1 cycle of sampling uncertainty).
- Pulse outputs (byte_valid, frame_error, orphan_data) are one cycle wide and never stick.

Decomposition:
- Shared package st7735_pkg holds:
  - state encodings RX_IDLE = 0, RX_SHIFT = 1;
  - ST7735 command constants: SLPOUT 8'h11, FRMCTR1 8'hB1, FRMCTR2 8'hB2, INVCTR 8'hB4, PWCTR1 8'hC0, GMCTRP1 8'hE0, GMCTRN1 8'hE1;
  - BITS_PER_BYTE = 8.
- One sub-module, st7735_sync_edge: SYNC_STAGES synchronizer plus rise/fall detect, instantiated once per input.

Test Plan:
- Single command: LCD_CLK at SYSTEM_CLK/8, CS low, DC = 0, shift 0x11, CS high -> exactly one byte_valid with byte_data = 0x11, byte_is_data = 0, cmd_code = 0x11, cmd_count = 1, no frame_error.
- Command plus parameters: command 0xB1, then DC = 1 parameters 0x01, 0x2C, 0x2D with CS low throughout -> four byte_valid pulses; the parameters report param_idx 0, 1, 2; cmd_code stays 0xB1.
- Truncated frame: CS low, 5 clock rises of 0xE0's MSBs, CS high -> one frame_error pulse, no byte_valid, cmd_code unchanged; a following full 0xE0 decodes correctly.
- Orphan and DC timing: after reset, DC = 1 byte 0xA5, with DC toggling during bits 1-7 but 1 at the 8th rise -> byte_valid, byte_is_data = 1, orphan_data pulses, cmd_count = 0.
- Reset mid-byte: assert SYSTEM_RST after 4 bits -> all outputs 0 asynchronously; after release, a fresh byte 0xC0 decodes cleanly with no frame_error.
- Saturation and wrap:
  - 40 parameters after command 0xE0 -> param_idx stops at 31.
  - cmd_count preloaded by forcing to 0xFFFF, plus one command -> 0x0000.

Source files
------------

// File: rtl/st7735_pkg.sv
// Shared definitions for the ST7735 SPI receiver: FSM encodings,
// panel command codes and byte geometry.
package st7735_pkg;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_FRMCTR1 = 8'hB1;
    localparam logic [7:0] CMD_FRMCTR2 = 8'hB2;
    localparam logic [7:0] CMD_INVCTR  = 8'hB4;
    localparam logic [7:0] CMD_PWCTR1  = 8'hC0;
    localparam logic [7:0] CMD_GMCTRP1 = 8'hE0;
    localparam logic [7:0] CMD_GMCTRN1 = 8'hE1;

    localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/st7735_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall
// detection on the synchronized value. STAGES must be at least 2.
module st7735_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Shift the raw input through the synchronizer chain and keep the
    // previous synchronized value for edge detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/st7735_spi_receiver.sv
// Write-only 4-wire SPI slave for the ST7735 bus. Oversamples CS/CLK/MOSI/DC
// in the SYSTEM_CLK domain and emits decoded command/parameter bytes.
// Valid/ready semantics: byte_valid is a one-cycle strobe with no back-pressure;
// byte_data/byte_is_data/cmd_code/param_idx are stable from the strobe cycle
// until the next strobe.
module st7735_spi_receiver
    import st7735_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PARAM_IDX_W = 5,
    parameter int CMD_CNT_W   = 16
) (
    input  logic                   SYSTEM_CLK,
    input  logic                   SYSTEM_RST,
    input  logic                   LCD_CS,
    input  logic                   LCD_CLK,
    input  logic                   LCD_MOSI,
    input  logic                   LCD_DC,
    output logic                   byte_valid,
    output logic [7:0]             byte_data,
    output logic                   byte_is_data,
    output logic [7:0]             cmd_code,
    output logic [PARAM_IDX_W-1:0] param_idx,
    output logic [CMD_CNT_W-1:0]   cmd_count,
    output logic                   frame_error,
    output logic                   orphan_data,
    output logic                   busy
);

    localparam logic [2:0]             LAST_BIT = 3'(BITS_PER_BYTE - 1);
    localparam logic [PARAM_IDX_W-1:0] IDX_MAX  = '1;

    logic w_cs_q, w_cs_rise, w_cs_fall;
    logic w_clk_q, w_clk_rise, w_clk_fall;
    logic w_mosi_q, w_mosi_rise, w_mosi_fall;
    logic w_dc_q, w_dc_rise, w_dc_fall;

    st7735_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .i_clk(SYSTEM_CLK), .i_rst(SYSTEM_RST), .i_d(LCD_CS),
        .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
    st7735_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_clk (
        .i_clk(SYSTEM_CLK), .i_rst(SYSTEM_RST), .i_d(LCD_CLK),
        .o_q(w_clk_q), .o_rise(w_clk_rise), .o_fall(w_clk_fall));
    st7735_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk(SYSTEM_CLK), .i_rst(SYSTEM_RST), .i_d(LCD_MOSI),
        .o_q(w_mosi_q), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));
    st7735_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dc (
        .i_clk(SYSTEM_CLK), .i_rst(SYSTEM_RST), .i_d(LCD_DC),
        .o_q(w_dc_q), .o_rise(w_dc_rise), .o_fall(w_dc_fall));

    // Edge strobes that this block has no use for.
    logic w_unused_edges;
    assign w_unused_edges = &{w_clk_q, w_clk_fall, w_mosi_rise, w_mosi_fall,
                              w_dc_rise, w_dc_fall};

    rx_state_t              r_state;
    logic [7:0]             r_sh;
    logic [2:0]             r_bit_cnt;
    logic                   r_have_cmd;
    logic [PARAM_IDX_W-1:0] r_next_idx;
    logic                   r_byte_valid;
    logic [7:0]             r_byte_data;
    logic                   r_byte_is_data;
    logic [7:0]             r_cmd_code;
    logic [PARAM_IDX_W-1:0] r_param_idx;
    logic [CMD_CNT_W-1:0]   r_cmd_count;
    logic                   r_frame_error;
    logic                   r_orphan_data;
    logic                   r_busy;

    logic [7:0] w_new_byte;
    logic       w_byte_done;

    // MOSI shares the synchronizer depth with CLK, so its current sample is
    // the bit that belongs to this rising edge.
    assign w_new_byte  = {r_sh[6:0], w_mosi_q};
    // While in SHIFT, synchronized CS is low except in its rising cycle, so
    // a rise is only ever accepted with CS low or in the CS-rise cycle itself.
    assign w_byte_done = (r_state == RX_SHIFT) && w_clk_rise && (r_bit_cnt == LAST_BIT);

    // Receive FSM: shifting, byte completion, command decode and framing checks.
    always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RST) begin
        if (SYSTEM_RST) begin
            r_state        <= RX_IDLE;
            r_sh           <= '0;
            r_bit_cnt      <= '0;
            r_have_cmd     <= 1'b0;
            r_next_idx     <= '0;
            r_byte_valid   <= 1'b0;
            r_byte_data    <= '0;
            r_byte_is_data <= 1'b0;
            r_cmd_code     <= '0;
            r_param_idx    <= '0;
            r_cmd_count    <= '0;
            r_frame_error  <= 1'b0;
            r_orphan_data  <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_byte_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_orphan_data <= 1'b0;
            r_busy        <= ~w_cs_q;
            case (r_state)
                RX_IDLE: begin
                    r_bit_cnt <= '0;
                    if (w_cs_fall) r_state <= RX_SHIFT;
                end
                RX_SHIFT: begin
                    if (w_clk_rise) begin
                        r_sh      <= w_new_byte;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    if (w_byte_done) begin
                        r_byte_valid   <= 1'b1;
                        r_byte_data    <= w_new_byte;
                        r_byte_is_data <= w_dc_q;
                        if (!w_dc_q) begin
                            r_cmd_code  <= w_new_byte;
                            r_param_idx <= '0;
                            r_next_idx  <= '0;
                            r_cmd_count <= r_cmd_count + CMD_CNT_W'(1);
                            r_have_cmd  <= 1'b1;
                        end else if (r_have_cmd) begin
                            r_param_idx <= r_next_idx;
                            if (r_next_idx != IDX_MAX) r_next_idx <= r_next_idx + PARAM_IDX_W'(1);
                        end else begin
                            r_orphan_data <= 1'b1;
                        end
                    end
                    if (w_cs_rise) begin
                        r_state   <= RX_IDLE;
                        r_bit_cnt <= '0;
                        // A partial byte (including one whose non-final rise
                        // lands with CS) is dropped and flagged.
                        if (!w_byte_done && (r_bit_cnt != 3'd0 || w_clk_rise))
                            r_frame_error <= 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign byte_valid   = r_byte_valid;
    assign byte_data    = r_byte_data;
    assign byte_is_data = r_byte_is_data;
    assign cmd_code     = r_cmd_code;
    assign param_idx    = r_param_idx;
    assign cmd_count    = r_cmd_count;
    assign frame_error  = r_frame_error;
    assign orphan_data  = r_orphan_data;
    assign busy         = r_busy;

endmodule
